// File: rtl/dht11_pkg.sv
`timescale 1ns/1ps
// Shared DHT11 definitions: FSM states, frame geometry and the checksum rule.
// The byte positions are also used by the downstream ASCII formatter.
package dht11_pkg;

  localparam int FRAME_BITS   = 40;
  localparam int DATA_BITS    = 32;
  localparam int BYTE_W       = 8;
  localparam int HUM_INT_MSB  = 39;
  localparam int HUM_DEC_MSB  = 31;
  localparam int TEMP_INT_MSB = 23;
  localparam int TEMP_DEC_MSB = 15;
  localparam int CHECKSUM_MSB = 7;

  typedef enum logic [3:0] {
    ST_POWER_UP  = 4'd0,
    ST_IDLE      = 4'd1,
    ST_START_LOW = 4'd2,
    ST_WAIT_ACK  = 4'd3,
    ST_ACK_LOW   = 4'd4,
    ST_ACK_HIGH  = 4'd5,
    ST_BIT_LOW   = 4'd6,
    ST_BIT_HIGH  = 4'd7,
    ST_CHECK     = 4'd8
  } dht11_state_e;

  // Sum of the four data bytes modulo 256 must equal the trailing byte.
  function automatic logic frame_checksum_ok(input logic [FRAME_BITS-1:0] frame);
    logic [BYTE_W-1:0] sum_s;
    sum_s = frame[HUM_INT_MSB -: BYTE_W] + frame[HUM_DEC_MSB -: BYTE_W]
          + frame[TEMP_INT_MSB -: BYTE_W] + frame[TEMP_DEC_MSB -: BYTE_W];
    return (sum_s == frame[CHECKSUM_MSB -: BYTE_W]);
  endfunction

endpackage

// File: rtl/dht11_tick_gen.sv
`timescale 1ns/1ps
// Free-running 1 us / 1 ms tick divider; both ticks are single-cycle
// registered pulses, the ms tick coinciding with every 1000th us tick.
module dht11_tick_gen #(
  parameter int CLK_FREQ_HZ = 50_000_000
) (
  input  logic sys_clk,
  input  logic sys_rst,
  output logic us_tick,
  output logic ms_tick
);

  localparam int US_DIV = CLK_FREQ_HZ / 1_000_000;
  localparam int US_W   = (US_DIV > 1) ? $clog2(US_DIV) : 1;
  localparam int MS_W   = 10;
  localparam logic [US_W-1:0] US_LAST = US_W'(US_DIV - 1);
  localparam logic [MS_W-1:0] MS_LAST = 10'd999;

  logic [US_W-1:0] us_cnt_r;
  logic [MS_W-1:0] ms_cnt_r;
  logic            us_wrap_s;
  logic            us_tick_r;
  logic            ms_tick_r;

  assign us_wrap_s = (us_cnt_r == US_LAST);

  // Cycle and microsecond counters with registered tick outputs.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      us_cnt_r  <= '0;
      ms_cnt_r  <= '0;
      us_tick_r <= 1'b0;
      ms_tick_r <= 1'b0;
    end else begin
      us_cnt_r  <= us_wrap_s ? '0 : us_cnt_r + 1'b1;
      if (us_wrap_s) begin
        ms_cnt_r <= (ms_cnt_r == MS_LAST) ? '0 : ms_cnt_r + 1'b1;
      end
      us_tick_r <= us_wrap_s;
      ms_tick_r <= us_wrap_s && (ms_cnt_r == MS_LAST);
    end
  end

  assign us_tick = us_tick_r;
  assign ms_tick = ms_tick_r;

endmodule

// File: rtl/dht11_sensor_if.sv
`timescale 1ns/1ps
// DHT11 single-wire bus master: periodic trigger, 40-bit frame capture,
// checksum validation and publication of the 32-bit reading.
module dht11_sensor_if
  import dht11_pkg::*;
#(
  parameter int CLK_FREQ_HZ    = 50_000_000,
  parameter int POWER_UP_MS    = 1000,
  parameter int POLL_MS        = 2000,
  parameter int START_LOW_MS   = 20,
  parameter int BIT1_THRESH_US = 50,
  parameter int TIMEOUT_US     = 200
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic                 dht_in,
  output logic                 dht_drive_low,
  output logic [DATA_BITS-1:0] data_valid,
  output logic                 data_update,
  output logic                 checksum_err,
  output logic                 timeout_err,
  output logic                 busy
);

  localparam int TMO_W  = $clog2(TIMEOUT_US + 1);
  localparam int MS_MAX = (POWER_UP_MS > POLL_MS)
                        ? ((POWER_UP_MS > START_LOW_MS) ? POWER_UP_MS : START_LOW_MS)
                        : ((POLL_MS > START_LOW_MS) ? POLL_MS : START_LOW_MS);
  localparam int MS_W   = $clog2(MS_MAX + 1);

  localparam logic [TMO_W-1:0] TMO_CNT   = TMO_W'(TIMEOUT_US);
  localparam logic [TMO_W-1:0] BIT1_CNT  = TMO_W'(BIT1_THRESH_US);
  localparam logic [MS_W-1:0]  PU_CNT    = MS_W'(POWER_UP_MS);
  localparam logic [MS_W-1:0]  POLL_CNT  = MS_W'(POLL_MS);
  localparam logic [MS_W-1:0]  SL_CNT    = MS_W'(START_LOW_MS);
  localparam logic [MS_W-1:0]  MS_SAT    = MS_W'(MS_MAX);
  localparam logic [5:0]       LAST_BIT  = 6'(FRAME_BITS - 1);

  dht11_state_e state_r;
  dht11_state_e state_next_s;

  logic [1:0]            sync_r;
  logic                  line_prev_r;
  logic                  fall_s;
  logic                  rise_s;
  logic                  us_tick_s;
  logic                  ms_tick_s;
  logic [TMO_W-1:0]      us_cnt_r;
  logic [MS_W-1:0]       ms_cnt_r;
  logic [FRAME_BITS-1:0] shift_r;
  logic [5:0]            bit_cnt_r;
  logic                  timed_s;
  logic                  timeout_s;
  logic                  shift_en_s;
  logic                  bit_val_s;
  logic                  state_chg_s;

  logic                  dht_drive_low_r;
  logic [DATA_BITS-1:0]  data_valid_r;
  logic                  data_update_r;
  logic                  checksum_err_r;
  logic                  timeout_err_r;
  logic                  busy_r;

  dht11_tick_gen #(
    .CLK_FREQ_HZ (CLK_FREQ_HZ)
  ) u_tick_gen (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .us_tick (us_tick_s),
    .ms_tick (ms_tick_s)
  );

  // Two-flop synchroniser plus previous-level flop for edge detection.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      sync_r      <= 2'b11;
      line_prev_r <= 1'b1;
    end else begin
      sync_r      <= {sync_r[0], dht_in};
      line_prev_r <= sync_r[1];
    end
  end

  assign fall_s      = line_prev_r & ~sync_r[1];
  assign rise_s      = ~line_prev_r & sync_r[1];
  assign timed_s     = (state_r == ST_WAIT_ACK) || (state_r == ST_ACK_LOW) ||
                       (state_r == ST_ACK_HIGH) || (state_r == ST_BIT_LOW) ||
                       (state_r == ST_BIT_HIGH);
  assign state_chg_s = (state_next_s != state_r);
  assign bit_val_s   = (us_cnt_r > BIT1_CNT);

  // Next-state decode; a phase timeout overrides every edge.
  always_comb begin
    state_next_s = state_r;
    timeout_s    = 1'b0;
    shift_en_s   = 1'b0;
    if (timed_s && (us_cnt_r == TMO_CNT)) begin
      timeout_s    = 1'b1;
      state_next_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_POWER_UP: begin
          if (ms_cnt_r == PU_CNT) state_next_s = ST_START_LOW;
          else                    state_next_s = ST_POWER_UP;
        end
        ST_IDLE: begin
          if (ms_cnt_r == POLL_CNT) state_next_s = ST_START_LOW;
          else                      state_next_s = ST_IDLE;
        end
        ST_START_LOW: begin
          if (ms_cnt_r == SL_CNT) state_next_s = ST_WAIT_ACK;
          else                    state_next_s = ST_START_LOW;
        end
        ST_WAIT_ACK: begin
          if (fall_s) state_next_s = ST_ACK_LOW;
          else        state_next_s = ST_WAIT_ACK;
        end
        ST_ACK_LOW: begin
          if (rise_s) state_next_s = ST_ACK_HIGH;
          else        state_next_s = ST_ACK_LOW;
        end
        ST_ACK_HIGH: begin
          if (fall_s) state_next_s = ST_BIT_LOW;
          else        state_next_s = ST_ACK_HIGH;
        end
        ST_BIT_LOW: begin
          if (rise_s) state_next_s = ST_BIT_HIGH;
          else        state_next_s = ST_BIT_LOW;
        end
        ST_BIT_HIGH: begin
          if (fall_s) begin
            shift_en_s = 1'b1;
            if (bit_cnt_r == LAST_BIT) state_next_s = ST_CHECK;
            else                       state_next_s = ST_BIT_LOW;
          end else begin
            state_next_s = ST_BIT_HIGH;
          end
        end
        ST_CHECK: state_next_s = ST_IDLE;
        default:  state_next_s = ST_POWER_UP;
      endcase
    end
  end

  // State register.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) state_r <= ST_POWER_UP;
    else         state_r <= state_next_s;
  end

  // Per-phase counters restart on every state change; the transition cycle
  // itself counts as the first elapsed microsecond.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      us_cnt_r <= '0;
      ms_cnt_r <= '0;
    end else if (state_chg_s) begin
      us_cnt_r <= us_tick_s ? TMO_W'(1) : '0;
      ms_cnt_r <= '0;
    end else begin
      if (us_tick_s && (us_cnt_r != TMO_CNT)) us_cnt_r <= us_cnt_r + 1'b1;
      if (ms_tick_s && (ms_cnt_r != MS_SAT))  ms_cnt_r <= ms_cnt_r + 1'b1;
    end
  end

  // Frame shift register, MSB first; emptied after CHECK or an abort.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      shift_r   <= '0;
      bit_cnt_r <= '0;
    end else if (timeout_s || (state_r == ST_CHECK)) begin
      shift_r   <= '0;
      bit_cnt_r <= '0;
    end else if (shift_en_s) begin
      shift_r   <= {shift_r[FRAME_BITS-2:0], bit_val_s};
      bit_cnt_r <= bit_cnt_r + 1'b1;
    end
  end

  // Registered outputs, derived from the state being entered.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      dht_drive_low_r <= 1'b0;
      data_valid_r    <= '0;
      data_update_r   <= 1'b0;
      checksum_err_r  <= 1'b0;
      timeout_err_r   <= 1'b0;
      busy_r          <= 1'b0;
    end else begin
      dht_drive_low_r <= (state_next_s == ST_START_LOW);
      busy_r          <= (state_next_s != ST_IDLE) && (state_next_s != ST_POWER_UP);
      timeout_err_r   <= timeout_s;
      data_update_r   <= 1'b0;
      checksum_err_r  <= 1'b0;
      if (state_r == ST_CHECK) begin
        if (frame_checksum_ok(shift_r)) begin
          data_valid_r  <= shift_r[FRAME_BITS-1 -: DATA_BITS];
          data_update_r <= 1'b1;
        end else begin
          checksum_err_r <= 1'b1;
        end
      end
    end
  end

  assign dht_drive_low = dht_drive_low_r;
  assign data_valid    = data_valid_r;
  assign data_update   = data_update_r;
  assign checksum_err  = checksum_err_r;
  assign timeout_err   = timeout_err_r;
  assign busy          = busy_r;

endmodule
